// File: rtl/cache_refill_controller.sv
// rtl/cache_refill_controller.sv - data-cache miss refill sequencer (way select, block read, fill, tag commit)
// Optional macro CACHE_REFILL_PERF_COUNTERS_EN adds saturating hit_count/miss_count outputs.
module cache_refill_controller #(
  parameter int ADDR_SIZE   = 32,
  parameter int NUM_SETS    = 16,
  parameter int NUM_WAYS    = 4,
  parameter int BLOCK_WORDS = 8,
  localparam int WAY_W  = $clog2(NUM_WAYS),
  localparam int SET_W  = $clog2(NUM_SETS),
  localparam int WORD_W = $clog2(BLOCK_WORDS),
  localparam int TAG_W  = ADDR_SIZE - SET_W - WORD_W - 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  input  logic [ADDR_SIZE-1:0] req_addr,
  output logic                 req_ready,
  input  logic                 hit,
  input  logic                 populated,
  input  logic [WAY_W-1:0]     populate_way,
  input  logic [WAY_W-1:0]     replace_way,
  output logic                 cru_enable,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ADDR_SIZE-1:0] mem_req_addr,
  input  logic                 mem_resp_valid,
  input  logic [31:0]          mem_resp_data,
  output logic                 fill_we,
  output logic                 fill_tag_we,
  output logic [WAY_W-1:0]     fill_way,
  output logic [SET_W-1:0]     fill_set,
  output logic [WORD_W-1:0]    fill_word,
  output logic [TAG_W-1:0]     fill_tag,
  output logic [31:0]          fill_data,
  output logic                 busy
`ifdef CACHE_REFILL_PERF_COUNTERS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam int OFS_W = WORD_W + 2;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, MEM_REQ, FILL, COMMIT} state_t;

  state_t                      state_q, state_d;
  logic [ADDR_SIZE-1:OFS_W]    blk_q;
  logic [WAY_W-1:0]            way_q;
  logic                        from_replace_q;
  logic [WORD_W-1:0]           count_q;
  logic                        miss_start;
  logic                        fill_beat;
  logic                        unused_offset;

  assign unused_offset = ^req_addr[OFS_W-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      blk_q          <= '0;
      way_q          <= '0;
      from_replace_q <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        blk_q          <= req_addr[ADDR_SIZE-1:OFS_W];
        way_q          <= populated ? populate_way : replace_way;
        from_replace_q <= !populated;
      end
      // BLOCK_WORDS is a power of two, so the last beat wraps the counter to 0.
      if (fill_beat) count_q <= count_q + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    cru_enable    = 1'b0;
    mem_req_valid = 1'b0;
    fill_we       = 1'b0;
    fill_tag_we   = 1'b0;
    miss_start    = 1'b0;
    fill_beat     = 1'b0;
    case (state_q)
      IDLE: begin
        // Hit outputs are combinational from inputs; hold them low while reset is asserted.
        if (rstn && req_valid) begin
          if (hit) begin
            req_ready  = 1'b1;
            cru_enable = 1'b1;
          end else begin
            miss_start = 1'b1;
            state_d    = MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = FILL;
      end
      FILL: begin
        if (mem_resp_valid) begin
          fill_we   = 1'b1;
          fill_beat = 1'b1;
          if (count_q == LAST_WORD) state_d = COMMIT;
        end
      end
      COMMIT: begin
        fill_tag_we = 1'b1;
        cru_enable  = from_replace_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign mem_req_addr = {blk_q, {OFS_W{1'b0}}};
  assign fill_way     = way_q;
  assign fill_set     = blk_q[OFS_W +: SET_W];
  assign fill_tag     = blk_q[ADDR_SIZE-1 -: TAG_W];
  assign fill_word    = count_q;
  assign fill_data    = mem_resp_data;

`ifdef CACHE_REFILL_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (req_ready && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      if (miss_start && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_refill_controller.sv
// tb/tb_cache_refill_controller.sv - randomized self-checking bench for cache_refill_controller
module tb_cache_refill_controller;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid, req_ready, hit, populated, cru_enable;
  logic [31:0] req_addr, mem_req_addr, mem_resp_data, fill_data;
  logic [1:0]  populate_way, replace_way, fill_way;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid, fill_we, fill_tag_we, busy;
  logic [3:0]  fill_set;
  logic [2:0]  fill_word;
  logic [22:0] fill_tag;
`ifdef CACHE_REFILL_PERF_COUNTERS_EN
  logic [31:0] hit_count, miss_count;
`endif
  int n_checks = 0;
  int n_fails  = 0;

  cache_refill_controller dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .hit(hit), .populated(populated), .populate_way(populate_way), .replace_way(replace_way),
    .cru_enable(cru_enable), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .fill_we(fill_we), .fill_tag_we(fill_tag_we), .fill_way(fill_way), .fill_set(fill_set),
    .fill_word(fill_word), .fill_tag(fill_tag), .fill_data(fill_data), .busy(busy)
`ifdef CACHE_REFILL_PERF_COUNTERS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = 1'b1; hit = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = $urandom;
    #2;
    n_checks++;
    if ({req_ready, cru_enable, busy, mem_req_valid, fill_we, fill_tag_we} !== 6'b0) begin
      n_fails++; $display("FAIL reset_ctrl: got %b want 000000", {req_ready, cru_enable, busy, mem_req_valid, fill_we, fill_tag_we});
    end
    n_checks++;
    if ({mem_req_addr, fill_way, fill_set, fill_word, fill_tag} !== 64'b0) begin
      n_fails++; $display("FAIL reset_fields: got %h want 0", {mem_req_addr, fill_way, fill_set, fill_word, fill_tag});
    end
    next_cycle();
    n_checks++;
    if (fill_data !== mem_resp_data) begin
      n_fails++; $display("FAIL reset_fill_data: got %h want %h", fill_data, mem_resp_data);
    end
    n_checks++;
    if ({req_ready, busy} !== 2'b0) begin
      n_fails++; $display("FAIL reset_after_edge: got %b want 00", {req_ready, busy});
    end
    req_valid = 1'b0; hit = 1'b0; mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
    rstn = 1'b1;
    next_cycle();
  endtask

  task automatic hit_cycle(input logic [31:0] a);
    req_valid = 1'b1; hit = 1'b1; req_addr = a; populated = $urandom; mem_resp_valid = $urandom;
    @(negedge clk);
    n_checks++;
    if ({req_ready, cru_enable, busy, mem_req_valid, fill_we} !== 5'b11000) begin
      n_fails++; $display("FAIL hit_outputs: addr %h got %b want 11000", a, {req_ready, cru_enable, busy, mem_req_valid, fill_we});
    end
    next_cycle();
    req_valid = 1'b0;
  endtask

  task automatic test_hit();
    hit_cycle(32'h0000_1044);
    for (int i = 0; i < 6; i++) hit_cycle($urandom);
    req_valid = 1'b0; hit = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req_ready, cru_enable, busy} !== 3'b000) begin
      n_fails++; $display("FAIL hit_no_valid: got %b want 000", {req_ready, cru_enable, busy});
    end
    next_cycle();
  endtask

  // gap_mode: 0 every cycle, 1 every other cycle, 2 random. addr_mode: 0 random core address while busy,
  // 1 core address moves to FFFF_FFC0 after word 3. abort_after: reset once that many words are written.
  task automatic do_miss(input logic [31:0] a, input logic pop, input logic [1:0] pw, input logic [1:0] rw,
                         input int req_delay, input int gap_mode, input int addr_mode, input int abort_after);
    logic [31:0] exp_set, exp_tag, exp_baddr, d;
    logic [1:0]  exp_way;
    int          req_cycles, words, cyc;
    bit          done;
    exp_way   = pop ? pw : rw;
    exp_set   = (a / 32) % 16;
    exp_tag   = a / 512;
    exp_baddr = a - (a % 32);

    req_valid = 1'b1; req_addr = a; hit = 1'b0; populated = pop; populate_way = pw; replace_way = rw;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req_ready, cru_enable, busy, mem_req_valid} !== 4'b0) begin
      n_fails++; $display("FAIL miss_idle: got %b want 0000", {req_ready, cru_enable, busy, mem_req_valid});
    end
    next_cycle();

    req_cycles = 0; done = 0;
    while (!done && req_cycles < 200) begin
      req_valid = $urandom; hit = $urandom; populated = $urandom; populate_way = $urandom; replace_way = $urandom;
      req_addr = (addr_mode == 0) ? $urandom : a;
      mem_req_ready = (req_cycles == req_delay);
      mem_resp_valid = $urandom; mem_resp_data = $urandom;
      @(negedge clk);
      n_checks++;
      if ({busy, mem_req_valid, req_ready, fill_we, fill_tag_we, cru_enable} !== 6'b110000) begin
        n_fails++; $display("FAIL mem_req_ctrl: cycle %0d got %b want 110000", req_cycles, {busy, mem_req_valid, req_ready, fill_we, fill_tag_we, cru_enable});
      end
      n_checks++;
      if (mem_req_addr !== exp_baddr) begin
        n_fails++; $display("FAIL mem_req_addr: got %h want %h", mem_req_addr, exp_baddr);
      end
      done = mem_req_ready;
      req_cycles++;
      next_cycle();
    end
    mem_req_ready = 1'b0;
    n_checks++;
    if (!done) begin
      n_fails++; $display("FAIL mem_req_timeout: got no handshake want handshake");
      return;
    end

    words = 0; cyc = 0;
    while (words < 8 && cyc < 400) begin
      if (abort_after >= 0 && words == abort_after) begin
        rstn = 1'b0; req_valid = 1'b1; hit = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = $urandom;
        #1;
        n_checks++;
        if ({req_ready, cru_enable, busy, mem_req_valid, fill_we, fill_tag_we} !== 6'b0) begin
          n_fails++; $display("FAIL abort_ctrl: got %b want 000000", {req_ready, cru_enable, busy, mem_req_valid, fill_we, fill_tag_we});
        end
        n_checks++;
        if ({mem_req_addr, fill_way, fill_set, fill_word, fill_tag} !== 64'b0) begin
          n_fails++; $display("FAIL abort_fields: got %h want 0", {mem_req_addr, fill_way, fill_set, fill_word, fill_tag});
        end
        next_cycle();
        n_checks++;
        if ({busy, fill_tag_we} !== 2'b00) begin
          n_fails++; $display("FAIL abort_hold: got %b want 00", {busy, fill_tag_we});
        end
        rstn = 1'b1; req_valid = 1'b0; hit = 1'b0; mem_resp_valid = 1'b0;
        next_cycle();
        return;
      end
      req_valid = $urandom; hit = $urandom; populated = $urandom; populate_way = $urandom; replace_way = $urandom;
      if (addr_mode == 0) req_addr = $urandom;
      else req_addr = (words >= 4) ? 32'hFFFF_FFC0 : a;
      mem_req_ready = $urandom;
      case (gap_mode)
        0:       mem_resp_valid = 1'b1;
        1:       mem_resp_valid = ((cyc % 2) == 0);
        default: mem_resp_valid = ($urandom_range(0, 2) != 0);
      endcase
      d = $urandom; mem_resp_data = d;
      @(negedge clk);
      n_checks++;
      if ({busy, mem_req_valid, req_ready, fill_tag_we, cru_enable, fill_we} !== {5'b10000, mem_resp_valid}) begin
        n_fails++; $display("FAIL fill_ctrl: word %0d got %b want %b", words, {busy, mem_req_valid, req_ready, fill_tag_we, cru_enable, fill_we}, {5'b10000, mem_resp_valid});
      end
      if (mem_resp_valid) begin
        n_checks++;
        if ({fill_word, fill_way, fill_set, fill_data} !== {words[2:0], exp_way, exp_set[3:0], d}) begin
          n_fails++; $display("FAIL fill_beat: got word %0d way %0d set %0d data %h want word %0d way %0d set %0d data %h",
                              fill_word, fill_way, fill_set, fill_data, words, exp_way, exp_set, d);
        end
        words++;
      end
      cyc++;
      next_cycle();
    end
    n_checks++;
    if (words < 8) begin
      n_fails++; $display("FAIL fill_timeout: got %0d words want 8", words);
      return;
    end

    req_valid = 1'b1; hit = $urandom; mem_resp_valid = $urandom; populated = $urandom;
    @(negedge clk);
    n_checks++;
    if ({fill_tag_we, fill_we, busy, mem_req_valid, req_ready, cru_enable} !== {4'b1010, 1'b0, !pop}) begin
      n_fails++; $display("FAIL commit_ctrl: got %b want %b", {fill_tag_we, fill_we, busy, mem_req_valid, req_ready, cru_enable}, {4'b1010, 1'b0, !pop});
    end
    n_checks++;
    if ({fill_tag, fill_set, fill_way} !== {exp_tag[22:0], exp_set[3:0], exp_way}) begin
      n_fails++; $display("FAIL commit_fields: got tag %h set %0d way %0d want tag %h set %0d way %0d",
                          fill_tag, fill_set, fill_way, exp_tag, exp_set, exp_way);
    end
    next_cycle();
    req_valid = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, fill_tag_we, fill_we} !== 3'b000) begin
      n_fails++; $display("FAIL back_to_idle: got %b want 000", {busy, fill_tag_we, fill_we});
    end
    next_cycle();
  endtask

  task automatic test_populate_miss();
    do_miss(32'h0000_1044, 1'b1, 2'd2, 2'd0, 3, 0, 1, -1);
    hit_cycle(32'h0000_1044);
  endtask

  task automatic test_replace_miss();
    do_miss(32'h0000_1044, 1'b0, 2'd3, 2'd1, 0, 1, 0, -1);
  endtask

  task automatic test_addr_change();
    do_miss(32'h0000_1044, 1'b0, 2'd0, 2'd3, 1, 2, 1, -1);
  endtask

  task automatic test_reset_mid_refill();
    do_miss(32'h0000_1044, 1'b1, 2'd2, 2'd0, 0, 0, 1, 5);
    do_miss(32'hABCD_0124, 1'b1, 2'd1, 2'd0, 2, 2, 0, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      for (int h = 0; h < int'($urandom_range(0, 2)); h++) hit_cycle($urandom);
      do_miss($urandom, 1'($urandom), 2'($urandom), 2'($urandom), $urandom_range(0, 4), 2, 0, -1);
    end
  endtask

`ifdef CACHE_REFILL_PERF_COUNTERS_EN
  task automatic test_perf_counters();
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({hit_count, miss_count} !== 64'b0) begin
      n_fails++; $display("FAIL perf_reset: got %h %h want 0 0", hit_count, miss_count);
    end
    next_cycle();
    rstn = 1'b1;
    next_cycle();
    for (int i = 0; i < 3; i++) hit_cycle($urandom);
    do_miss($urandom, 1'b1, 2'd1, 2'd2, 1, 0, 0, -1);
    do_miss($urandom, 1'b0, 2'd1, 2'd2, 0, 2, 0, -1);
    n_checks++;
    if (hit_count !== 32'd3 || miss_count !== 32'd2) begin
      n_fails++; $display("FAIL perf_counts: got hit %0d miss %0d want hit 3 miss 2", hit_count, miss_count);
    end
    dut.hit_count = 32'hFFFF_FFFF;
    hit_cycle($urandom);
    n_checks++;
    if (hit_count !== 32'hFFFF_FFFF) begin
      n_fails++; $display("FAIL perf_saturate: got %h want ffffffff", hit_count);
    end
  endtask
`endif

  initial begin
    req_valid = 1'b0; req_addr = '0; hit = 1'b0; populated = 1'b0; populate_way = '0; replace_way = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    test_reset();
    test_hit();
    test_populate_miss();
    test_replace_miss();
    test_addr_change();
    test_reset_mid_refill();
    test_back_to_back();
`ifdef CACHE_REFILL_PERF_COUNTERS_EN
    test_perf_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
